pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Holds the architectural PC and fetches the instruction at PC over a req/gnt/rvalid
//  instruction-memory handshake, then presents it to decode with valid/ready.
//  Consumes the next-PC value computed by the next-PC logic (PC+4, branch or jump target)
//  when decode accepts the current instruction. Sits between the next-PC logic and the
//  IMEM/decode boundary of the CPU.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC value loaded on reset
//  CNT_W      32             width of retired-instruction counter
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous reset, active-high
//  npc_i         in   32     next PC from next-PC logic; sampled only on accept
//  imem_req_o    out  1      fetch request
//  imem_addr_o   out  32     fetch address (= pc_o)
//  imem_gnt_i    in   1      IMEM accepted request this cycle
//  imem_rvalid_i in   1      IMEM read data valid this cycle
//  imem_rdata_i  in   32     IMEM read data
//  pc_o          out  32     current PC
//  instr_o       out  32     instruction at pc_o
//  instr_valid_o out  1      instr_o valid
//  instr_ready_i in   1      decode accepts instr_o; npc_i valid in same cycle
//  fault_o       out  1      sticky: misaligned next PC
//  retire_cnt_o  out  CNT_W  count of accepted instructions
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc_o=RESET_PC, imem_req_o=0, instr_o=0,
//   instr_valid_o=0, fault_o=0, retire_cnt_o=0. imem_addr_o always equals pc_o.
//  States: IDLE, FETCH, WAIT, VALID, FAULT.
//  IDLE: one cycle after reset release -> FETCH.
//  FETCH: imem_req_o=1; pc_o/imem_addr_o stable. gnt=1 -> WAIT; else hold (req stays 1).
//  WAIT: imem_req_o=0. rvalid=1 -> instr_o<=rdata, instr_valid_o<=1, -> VALID.
//   rvalid is never returned in the same cycle as gnt; rvalid outside WAIT is ignored.
//  VALID: instr_valid_o=1, instr_o held. instr_ready_i=1 (accept):
//   retire_cnt_o += 1 (wraps modulo 2^CNT_W); instr_valid_o<=0;
//   if npc_i[1:0]==2'b00: pc_o<=npc_i -> FETCH;
//   else: pc_o unchanged, fault_o<=1 -> FAULT.
//   instr_ready_i ignored in all states except VALID.
//  FAULT: terminal until reset; imem_req_o=0, instr_valid_o=0, fault_o=1.
//  Minimum latency: accept in cycle N -> req in N+1 -> gnt in N+1 -> rvalid N+2
//   -> instr_valid_o high in N+3 (3 cycles per instruction, zero-wait IMEM).
//  npc_i==pc_o (self-loop) is legal: refetches same address.
//  pc_o wraps naturally; npc_i=32'hFFFF_FFFC accepted as aligned.
//  Reset asserted in WAIT/VALID: outstanding transaction dropped; a late rvalid after
//   reset is ignored (state not WAIT).
// TESTING
//  Reset release, gnt=1 first cycle, rvalid next, rdata=32'h2408_0005 -> addr 0x3000,
//   instr_valid_o=1 with instr_o=0x24080005 three cycles after release.
//  Sequential: accept with npc_i=0x3004, then 0x3008 -> fetch addrs 0x3000,0x3004,
//   0x3008; retire_cnt_o=2 after the second accept.
//  Jump: accept with npc_i=0x0000_3040 -> next imem_addr_o=0x3040; gnt withheld 4
//   cycles -> req/addr held stable all 4.
//  Decode stall: instr_ready_i=0 for 5 cycles in VALID -> instr_o/pc_o unchanged,
//   no req.
//  Misaligned: accept with npc_i=0x3006 -> fault_o=1, pc_o stays, req never again
//   until rst.
//  Async reset mid-WAIT, rvalid pulses 1 cycle after rst falls -> ignored; fetch
//   restarts at 0x3000.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Holds the architectural PC, fetches the instruction at PC over req/gnt/rvalid, hands it to decode.
// Latency: 3 cycles from decode accept to the next instr_valid_o with a zero-wait IMEM.
// Backpressure: instr_valid_o stays high and instr_o/pc_o stay put until instr_ready_i; no fetch meanwhile.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      npc_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      instr_o,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic             fault_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and datapath registers; reset drops any outstanding IMEM transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: rvalid only matters in WAIT, decode ready only in VALID.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (imem_gnt_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (instr_ready_i) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (npc_i[1:0] == 2'b00) begin
            pc_d    = npc_i;
            state_d = ST_FETCH;
          end else begin
            // Misaligned target: keep the PC of the offending instruction for debug.
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign imem_req_o    = (state_q == ST_FETCH);
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = (state_q == ST_VALID);
  assign fault_o       = fault_q;
  assign retire_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        fault_o;
  logic [31:0] retire_cnt_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .npc_i(npc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .instr_o(instr_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .fault_o(fault_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  // IMEM contents seen by the bench.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0005;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, grant it after gnt_delay cycles, return data next cycle.
  task automatic serve(input int gnt_delay, output logic [31:0] addr_seen, output logic ok);
    int n;
    n = 0;
    ok = 1'b0;
    addr_seen = 32'hx;
    while (!imem_req_o && n < 20) begin
      step();
      n++;
    end
    if (!imem_req_o) return;
    for (int i = 0; i < gnt_delay; i++) step();
    addr_seen = imem_addr_o;
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = mem_word(addr_seen);
    step();
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0;
    ok = 1'b1;
  endtask

  task automatic accept(input logic [31:0] npc);
    instr_ready_i = 1'b1;
    npc_i = npc;
    step();
    instr_ready_i = 1'b0;
    npc_i = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_cmp++;
    if ({imem_req_o, instr_valid_o, fault_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl: got req/valid/fault=%b want 000", {imem_req_o, instr_valid_o, fault_o});
    end
    n_cmp++;
    if (pc_o !== 32'h3000 || imem_addr_o !== 32'h3000) begin
      n_err++; $display("FAIL reset_pc: got pc=%h addr=%h want 3000", pc_o, imem_addr_o);
    end
    n_cmp++;
    if (instr_o !== 32'h0 || retire_cnt_o !== 32'h0) begin
      n_err++; $display("FAIL reset_data: got instr=%h cnt=%0d want 0/0", instr_o, retire_cnt_o);
    end
  endtask

  task automatic test_first_fetch();
    exp_t e;
    exp_q.push_back('{pc: 32'h3000, instr: 32'h2408_0005});
    rst = 1'b0;
    n_cmp++;
    if (imem_req_o !== 1'b0) begin
      n_err++; $display("FAIL idle_req: got %b want 0", imem_req_o);
    end
    step();
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3000) begin
      n_err++; $display("FAIL first_req: got req=%b addr=%h want 1/3000", imem_req_o, imem_addr_o);
    end
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    n_cmp++;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      n_err++; $display("FAIL wait_state: got req=%b valid=%b want 0/0", imem_req_o, instr_valid_o);
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h2408_0005;
    step();
    imem_rvalid_i = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== e.instr || pc_o !== e.pc) begin
      n_err++; $display("FAIL first_instr: got v=%b instr=%h pc=%h want 1/%h/%h", instr_valid_o, instr_o, pc_o, e.instr, e.pc);
    end
  endtask

  task automatic test_sequential();
    exp_t e;
    logic [31:0] a;
    logic ok;
    logic [31:0] npcs [2];
    npcs[0] = 32'h3004;
    npcs[1] = 32'h3008;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{pc: npcs[k], instr: mem_word(npcs[k])});
      accept(npcs[k]);
      serve(0, a, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || a !== e.pc) begin
        n_err++; $display("FAIL seq_addr%0d: got ok=%b addr=%h want 1/%h", k, ok, a, e.pc);
      end
      n_cmp++;
      if (instr_valid_o !== 1'b1 || instr_o !== e.instr || pc_o !== e.pc) begin
        n_err++; $display("FAIL seq_instr%0d: got v=%b instr=%h pc=%h want 1/%h/%h", k, instr_valid_o, instr_o, pc_o, e.instr, e.pc);
      end
    end
    n_cmp++;
    if (retire_cnt_o !== 32'd2) begin
      n_err++; $display("FAIL seq_cnt: got %0d want 2", retire_cnt_o);
    end
  endtask

  task automatic test_jump();
    exp_t e;
    logic [31:0] a;
    logic ok;
    int bad;
    exp_q.push_back('{pc: 32'h3040, instr: mem_word(32'h3040)});
    accept(32'h3040);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3040) bad++;
      step();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL jump_hold: %0d of 4 cycles had req/addr wrong, want req=1 addr=3040", bad);
    end
    serve(0, a, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || a !== e.pc || instr_o !== e.instr || instr_valid_o !== 1'b1) begin
      n_err++; $display("FAIL jump_instr: got ok=%b addr=%h instr=%h v=%b want 1/%h/%h/1", ok, a, instr_o, instr_valid_o, e.pc, e.instr);
    end
    n_cmp++;
    if (retire_cnt_o !== 32'd3) begin
      n_err++; $display("FAIL jump_cnt: got %0d want 3", retire_cnt_o);
    end
  endtask

  task automatic test_stall();
    int bad;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      // Stray read data outside WAIT must not disturb the held instruction.
      imem_rvalid_i = (i == 2);
      imem_rdata_i = 32'hDEAD_BEEF;
      step();
      if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0 || instr_o !== mem_word(32'h3040) || pc_o !== 32'h3040) bad++;
    end
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0;
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL stall_hold: %0d of 5 cycles changed, want instr=%h pc=3040 held", bad, mem_word(32'h3040));
    end
  endtask

  task automatic test_wrap_and_self_loop();
    exp_t e;
    logic [31:0] a;
    logic ok;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{pc: 32'hFFFF_FFFC, instr: mem_word(32'hFFFF_FFFC)});
      accept(32'hFFFF_FFFC);
      serve(0, a, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || a !== e.pc || instr_o !== e.instr || pc_o !== e.pc) begin
        n_err++; $display("FAIL top_fetch%0d: got ok=%b addr=%h instr=%h pc=%h want 1/%h/%h", k, ok, a, instr_o, pc_o, e.pc, e.instr);
      end
    end
    n_cmp++;
    if (retire_cnt_o !== 32'd5) begin
      n_err++; $display("FAIL top_cnt: got %0d want 5", retire_cnt_o);
    end
  endtask

  task automatic test_misaligned();
    int bad;
    accept(32'h3006);
    n_cmp++;
    if (fault_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC || instr_valid_o !== 1'b0) begin
      n_err++; $display("FAIL mis_state: got fault=%b pc=%h v=%b want 1/fffffffc/0", fault_o, pc_o, instr_valid_o);
    end
    n_cmp++;
    if (retire_cnt_o !== 32'd6) begin
      n_err++; $display("FAIL mis_cnt: got %0d want 6", retire_cnt_o);
    end
    bad = 0;
    instr_ready_i = 1'b1;
    npc_i = 32'h3000;
    for (int i = 0; i < 8; i++) begin
      imem_gnt_i = i[0];
      imem_rvalid_i = ~i[0];
      step();
      if (imem_req_o !== 1'b0 || fault_o !== 1'b1 || instr_valid_o !== 1'b0 || pc_o !== 32'hFFFF_FFFC) bad++;
    end
    instr_ready_i = 1'b0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL mis_terminal: %0d of 8 cycles left FAULT, want req=0 fault=1", bad);
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    logic [31:0] a;
    logic ok;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    // Now in WAIT: assert reset between edges.
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (pc_o !== 32'h3000 || fault_o !== 1'b0 || retire_cnt_o !== 32'h0 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      n_err++; $display("FAIL async_rst: got pc=%h fault=%b cnt=%0d req=%b v=%b want 3000/0/0/0/0", pc_o, fault_o, retire_cnt_o, imem_req_o, instr_valid_o);
    end
    step();
    rst = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hBAD0_BAD0;
    step();
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0;
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3000 || instr_valid_o !== 1'b0) begin
      n_err++; $display("FAIL late_rvalid: got req=%b addr=%h v=%b want 1/3000/0", imem_req_o, imem_addr_o, instr_valid_o);
    end
    exp_q.push_back('{pc: 32'h3000, instr: 32'h2408_0005});
    serve(1, a, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || a !== e.pc || instr_o !== e.instr || instr_valid_o !== 1'b1) begin
      n_err++; $display("FAIL restart: got ok=%b addr=%h instr=%h v=%b want 1/%h/%h/1", ok, a, instr_o, instr_valid_o, e.pc, e.instr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_jump();
    test_stall();
    test_wrap_and_self_loop();
    test_misaligned();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
